// File: rtl/char_pkg.sv
// Shared constants, types and recolour helper for the character fetch arbiter.
// Palette, sprite geometry and requester identity live here.
package char_pkg;

  localparam int ADDR_W = 12;
  localparam int SPRITE_W = 44;
  localparam int SPRITE_H = 65;
  localparam int MEM_DEPTH = SPRITE_W * SPRITE_H;
  localparam logic [3:0] TRANSPARENT_IDX = 4'd1;

  typedef enum logic {
    REQ_PLAYER = 1'b0,
    REQ_NPC    = 1'b1
  } req_e;

  // Entry 0 first; index 15 is unpopulated.
  localparam logic [0:14][23:0] PALETTE = {
    24'h282828, 24'hfba500, 24'h1e3791, 24'hd8c8a0,
    24'h664911, 24'hf0c8a0, 24'ha07850, 24'hffffff,
    24'h3c7c3c, 24'hc03030, 24'hffd700, 24'h5a5a5a,
    24'h850305, 24'h2050c0, 24'h101010
  };

  function automatic logic [3:0] npc_recolour(input logic [3:0] idx);
    logic [3:0] r;
    r = idx;
    if (idx == 4'd2) r = 4'd12;
    else if (idx == 4'd12) r = 4'd2;
    return r;
  endfunction

endpackage

// File: rtl/char_palette_lut.sv
// Palette lookup: 4-bit index plus requester identity to RGB and pixel-on.
// The NPC robe/medallion swap is applied before lookup.
module char_palette_lut
  import char_pkg::*;
#(
  parameter logic [3:0] TRANSP_IDX = TRANSPARENT_IDX
) (
  input  logic [3:0]  i_idx,
  input  logic        i_is_npc,
  output logic [23:0] o_pixel,
  output logic        o_pixel_on
);

  logic [3:0]        w_idx;
  logic [0:15][23:0] w_pal;

  assign w_pal      = {PALETTE, 24'h000000};
  assign w_idx      = i_is_npc ? npc_recolour(i_idx) : i_idx;
  assign o_pixel    = w_pal[w_idx];
  assign o_pixel_on = (w_idx != TRANSP_IDX);

endmodule

// File: rtl/char_fetch_arbiter.sv
// Round-robin arbiter sharing one sprite memory port between Player and NPC.
// Optional grant/conflict counters under CHAR_ARB_STATS_EN.
module char_fetch_arbiter #(
  parameter int         ADDR_W          = char_pkg::ADDR_W,
  parameter int         MEM_DEPTH       = char_pkg::MEM_DEPTH,
  parameter logic [3:0] TRANSPARENT_IDX = char_pkg::TRANSPARENT_IDX
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              player_valid,
  input  logic [ADDR_W-1:0] player_addr,
  output logic              player_ready,
  input  logic              npc_valid,
  input  logic [ADDR_W-1:0] npc_addr,
  output logic              npc_ready,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [3:0]        mem_data,
  output logic              player_rsp_valid,
  output logic [23:0]       player_pixel,
  output logic              player_pixel_on,
  output logic              npc_rsp_valid,
  output logic [23:0]       npc_pixel,
  output logic              npc_pixel_on
`ifdef CHAR_ARB_STATS_EN
  ,
  input  logic              frame_start,
  output logic [15:0]       player_grants,
  output logic [15:0]       npc_grants,
  output logic [15:0]       conflicts
`endif
);

  char_pkg::req_e    r_rr_ptr;
  logic              r_s1_vld;
  char_pkg::req_e    r_s1_own;
  logic              r_s1_oor;
  logic              r_s2_vld;
  char_pkg::req_e    r_s2_own;
  logic              r_s2_oor;
  logic [3:0]        r_s2_data;
  logic              r_p_vld;
  logic [23:0]       r_p_pix;
  logic              r_p_on;
  logic              r_n_vld;
  logic [23:0]       r_n_pix;
  logic              r_n_on;

  logic              w_gnt_p;
  logic              w_gnt_n;
  logic              w_acc;
  logic [ADDR_W-1:0] w_addr;
  logic              w_in_rng;
  logic [23:0]       w_pix;
  logic              w_on;

  // Reset gating keeps the port quiet while held in reset.
  assign w_gnt_p = Reset_n & player_valid
                 & (~npc_valid | (r_rr_ptr == char_pkg::REQ_PLAYER));
  assign w_gnt_n = Reset_n & npc_valid
                 & (~player_valid | (r_rr_ptr == char_pkg::REQ_NPC));
  assign w_acc    = w_gnt_p | w_gnt_n;
  assign w_addr   = w_gnt_n ? npc_addr : player_addr;
  assign w_in_rng = (int'(w_addr) < MEM_DEPTH);

  assign player_ready = w_gnt_p;
  assign npc_ready    = w_gnt_n;
  assign mem_en       = w_acc & w_in_rng;
  assign mem_addr     = (w_acc & w_in_rng) ? w_addr : '0;

  char_palette_lut #(
    .TRANSP_IDX (TRANSPARENT_IDX)
  ) u_lut (
    .i_idx      (r_s2_data),
    .i_is_npc   (r_s2_own == char_pkg::REQ_NPC),
    .o_pixel    (w_pix),
    .o_pixel_on (w_on)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rr_ptr  <= char_pkg::REQ_PLAYER;
      r_s1_vld  <= 1'b0;
      r_s1_own  <= char_pkg::REQ_PLAYER;
      r_s1_oor  <= 1'b0;
      r_s2_vld  <= 1'b0;
      r_s2_own  <= char_pkg::REQ_PLAYER;
      r_s2_oor  <= 1'b0;
      r_s2_data <= 4'd0;
      r_p_vld   <= 1'b0;
      r_p_pix   <= 24'h0;
      r_p_on    <= 1'b0;
      r_n_vld   <= 1'b0;
      r_n_pix   <= 24'h0;
      r_n_on    <= 1'b0;
    end else begin
      if (w_acc)
        r_rr_ptr <= w_gnt_p ? char_pkg::REQ_NPC : char_pkg::REQ_PLAYER;
      r_s1_vld  <= w_acc;
      r_s1_own  <= w_gnt_n ? char_pkg::REQ_NPC : char_pkg::REQ_PLAYER;
      r_s1_oor  <= w_acc & ~w_in_rng;
      r_s2_vld  <= r_s1_vld;
      r_s2_own  <= r_s1_own;
      r_s2_oor  <= r_s1_oor;
      r_s2_data <= mem_data;
      r_p_vld   <= r_s2_vld & (r_s2_own == char_pkg::REQ_PLAYER);
      r_n_vld   <= r_s2_vld & (r_s2_own == char_pkg::REQ_NPC);
      if (r_s2_vld && r_s2_own == char_pkg::REQ_PLAYER) begin
        r_p_pix <= r_s2_oor ? 24'h0 : w_pix;
        r_p_on  <= r_s2_oor ? 1'b0 : w_on;
      end
      if (r_s2_vld && r_s2_own == char_pkg::REQ_NPC) begin
        r_n_pix <= r_s2_oor ? 24'h0 : w_pix;
        r_n_on  <= r_s2_oor ? 1'b0 : w_on;
      end
    end
  end

  assign player_rsp_valid = r_p_vld;
  assign player_pixel     = r_p_pix;
  assign player_pixel_on  = r_p_on;
  assign npc_rsp_valid    = r_n_vld;
  assign npc_pixel        = r_n_pix;
  assign npc_pixel_on     = r_n_on;

`ifdef CHAR_ARB_STATS_EN
  logic [15:0] r_pg;
  logic [15:0] r_ng;
  logic [15:0] r_cf;

  // Frame clear takes priority over a same-cycle increment.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pg <= 16'h0;
      r_ng <= 16'h0;
      r_cf <= 16'h0;
    end else if (frame_start) begin
      r_pg <= 16'h0;
      r_ng <= 16'h0;
      r_cf <= 16'h0;
    end else begin
      if (w_gnt_p && r_pg != 16'hFFFF)
        r_pg <= r_pg + 16'd1;
      if (w_gnt_n && r_ng != 16'hFFFF)
        r_ng <= r_ng + 16'd1;
      if (player_valid && npc_valid && r_cf != 16'hFFFF)
        r_cf <= r_cf + 16'd1;
    end
  end

  assign player_grants = r_pg;
  assign npc_grants    = r_ng;
  assign conflicts     = r_cf;
`endif

endmodule
